// File: rtl/sub_fp_pkg.sv
// sub_fp_pkg: width helpers and saturation constants shared by the fixed-point pipeline
package sub_fp_pkg;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int calc_nbf_fr(input int nbf_a, input int nbf_b);
        return max_int(nbf_a, nbf_b);
    endfunction

    // one extra integer bit keeps the difference exact for any operand pair
    function automatic int calc_nbi_fr(input int nb_a, input int nbf_a, input int nb_b, input int nbf_b);
        return max_int(nb_a - nbf_a, nb_b - nbf_b) + 1;
    endfunction

    function automatic int calc_nb_fr(input int nb_a, input int nbf_a, input int nb_b, input int nbf_b);
        return calc_nbi_fr(nb_a, nbf_a, nb_b, nbf_b) + calc_nbf_fr(nbf_a, nbf_b);
    endfunction

    // 0 followed by all ones in an nb-bit word
    function automatic logic [63:0] sat_pos(input int nb);
        return (64'd1 << (nb - 1)) - 64'd1;
    endfunction

    // 1 followed by all zeros in an nb-bit word
    function automatic logic [63:0] sat_neg(input int nb);
        return 64'd1 << (nb - 1);
    endfunction

endpackage

// File: rtl/sub_fp_round_sat.sv
// fp_round_sat: combinational round-half-up and saturate from one signed Q format to a narrower one
module fp_round_sat
    import sub_fp_pkg::*;
#(
    parameter int NB_IN   = 17,
    parameter int NBF_IN  = 14,
    parameter int NB_OUT  = 11,
    parameter int NBF_OUT = 10
) (
    input  logic [NB_IN-1:0]  value,
    output logic [NB_OUT-1:0] result,
    output logic              sat
);

    localparam int SH   = NBF_IN - NBF_OUT;
    localparam int NB_R = NB_IN + 1 - SH;
    localparam logic [63:0] POS = sat_pos(NB_OUT);
    localparam logic [63:0] NEG = sat_neg(NB_OUT);

    logic [NB_R-1:0] rs;
    logic            fits;

    // the add is one bit wider than the input so the rounding carry cannot wrap the sign
    generate
        if (SH > 0) begin : g_round
            localparam logic [NB_IN:0] HALF = {{NB_IN{1'b0}}, 1'b1} << (SH - 1);
            assign rs = NB_R'(({value[NB_IN-1], value} + HALF) >> SH);
        end else begin : g_pass
            assign rs = {value[NB_IN-1], value};
        end
    endgenerate

    // clamp when the dropped integer bits and the output sign bit disagree
    always_comb begin
        fits   = (&rs[NB_R-1:NB_OUT-1]) | ~(|rs[NB_R-1:NB_OUT-1]);
        sat    = ~fits;
        result = fits ? rs[NB_OUT-1:0] : (rs[NB_R-1] ? NEG[NB_OUT-1:0] : POS[NB_OUT-1:0]);
    end

endmodule

// File: rtl/sub_fp_pipe.sv
// sub_fp_pipe: three-stage fixed-point subtractor with valid/ready flow control and overflow counter
module sub_fp_pipe
    import sub_fp_pkg::*;
#(
    parameter int NB_IN_A  = 16,
    parameter int NBF_IN_A = 14,
    parameter int NB_IN_B  = 12,
    parameter int NBF_IN_B = 11,
    parameter int NB_OUT   = 11,
    parameter int NBF_OUT  = 10,
    parameter int NB_CNT   = 8,
    localparam int NBI_FR  = calc_nbi_fr(NB_IN_A, NBF_IN_A, NB_IN_B, NBF_IN_B),
    localparam int NBF_FR  = calc_nbf_fr(NBF_IN_A, NBF_IN_B),
    localparam int NB_FR   = calc_nb_fr(NB_IN_A, NBF_IN_A, NB_IN_B, NBF_IN_B)
) (
    input  logic               i_clock,
    input  logic               i_rst_n,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [NB_IN_A-1:0] i_A,
    input  logic [NB_IN_B-1:0] i_B,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [NB_FR-1:0]   o_diffFR,
    output logic [NB_OUT-1:0]  o_diff_round_sat,
    output logic               o_sat_flag,
    output logic [NB_CNT-1:0]  o_sat_cnt,
    input  logic               i_clear_cnt
);

    localparam int SHA = NBF_FR - NBF_IN_A;
    localparam int SHB = NBF_FR - NBF_IN_B;

    logic              adv, v1, v2, v3, sat3, sat_c;
    logic [NB_FR-1:0]  a_al, b_al, a1, b1, d2, d3;
    logic [NB_OUT-1:0] q3, rnd;
    logic [NB_CNT-1:0] cnt;

    assign a_al = {{(NB_FR-NB_IN_A){i_A[NB_IN_A-1]}}, i_A} << SHA;
    assign b_al = {{(NB_FR-NB_IN_B){i_B[NB_IN_B-1]}}, i_B} << SHB;

    assign adv              = ~v3 | i_ready;
    assign o_ready          = adv;
    assign o_valid          = v3;
    assign o_diffFR         = d3;
    assign o_diff_round_sat = q3;
    assign o_sat_flag       = sat3;
    assign o_sat_cnt        = cnt;

    fp_round_sat #(
        .NB_IN  (NB_FR),
        .NBF_IN (NBF_FR),
        .NB_OUT (NB_OUT),
        .NBF_OUT(NBF_OUT)
    ) u_round_sat (
        .value (d2),
        .result(rnd),
        .sat   (sat_c)
    );

    // all stages move in lockstep on adv; bubbles travel with the data
    always_ff @(posedge i_clock or negedge i_rst_n) begin
        if (!i_rst_n) begin
            v1   <= 1'b0;
            v2   <= 1'b0;
            v3   <= 1'b0;
            a1   <= '0;
            b1   <= '0;
            d2   <= '0;
            d3   <= '0;
            q3   <= '0;
            sat3 <= 1'b0;
        end else if (adv) begin
            v1   <= i_valid;
            a1   <= a_al;
            b1   <= b_al;
            v2   <= v1;
            d2   <= a1 - b1;
            v3   <= v2;
            d3   <= d2;
            q3   <= rnd;
            sat3 <= sat_c;
        end
    end

    // count clamped words taken downstream, sticking at all-ones; clear wins
    always_ff @(posedge i_clock or negedge i_rst_n) begin
        if (!i_rst_n)
            cnt <= '0;
        else if (i_clear_cnt)
            cnt <= '0;
        else if (v3 & i_ready & sat3 & ~&cnt)
            cnt <= cnt + NB_CNT'(1);
    end

endmodule

// File: doc/sub_fp_pipe.md
# sub_fp_pipe

Pipelined fixed-point subtractor computing D = A − B for two signed operands in independent Qm.n formats. It produces a full-resolution difference and a round-half-up, saturated output in a narrower format. Valid/ready handshaking is used on both sides, and a saturating counter tracks overflow events. It is the subtraction counterpart of the combinational fixed-point adder and is intended for registered datapaths that need backpressure.

## Interface
- NB_IN_A, 16: total bits of A
- NBF_IN_A, 14: fractional bits of A
- NB_IN_B, 12: total bits of B
- NBF_IN_B, 11: fractional bits of B
- NB_OUT, 11: total bits of rounded/saturated output
- NBF_OUT, 10: fractional bits of output; NBF_OUT ≤ max(NBF_IN_A, NBF_IN_B)
- NB_CNT, 8: saturation counter width
- Derived (localparams): NBI_FR = max(NBI_A, NBI_B) + 1, NBF_FR = max(NBF_IN_A, NBF_IN_B), NB_FR = NBI_FR + NBF_FR (defaults: 3 + 14 = 17)
- i_clock  in  1  rising-edge clock
- i_rst_n  in  1  asynchronous, active-low reset
- i_valid  in  1  input operands valid
- o_ready  out  1  block accepts operands this cycle
- i_A  in  NB_IN_A  signed operand A
- i_B  in  NB_IN_B  signed operand B
- o_valid  out  1  output valid
- i_ready  in  1  downstream accepts output
- o_diffFR  out  NB_FR  full-resolution A − B, never overflows
- o_diff_round_sat  out  NB_OUT  rounded and saturated A − B
- o_sat_flag  out  1  saturation occurred on the current output word
- o_sat_cnt  out  NB_CNT  count of saturated words accepted downstream; sticks at all-ones
- i_clear_cnt  in  1  synchronous clear of o_sat_cnt

## Operation
- Stage 1: register A and B after binary-point alignment. The operand with fewer fractional bits is left-shifted with zero fill. Both are sign-extended to NB_FR.
- Stage 2: D_FR = A_al − B_al at NB_FR bits. This width is exact for all inputs.
- Stage 3 rounding: add 2^(NBF_FR−NBF_OUT−1) to D_FR at NB_FR+1 bits, then drop the NBF_FR−NBF_OUT LSBs. Ties round toward +∞. When NBF_FR = NBF_OUT, no rounding is applied.
- Stage 3 saturation: if the discarded upper integer bits plus the output sign bit are not all-equal, clamp the result.
  - Positive overflow gives 0 followed by all ones.
  - Negative overflow gives 1 followed by all zeros.
  - o_sat_flag is set to 1 whenever a clamp occurs.
- o_diffFR carries the stage-3 full-resolution value, aligned with o_diff_round_sat.
- Counter increments on o_valid & i_ready & o_sat_flag and stops at 2^NB_CNT−1.
- i_clear_cnt has priority over the increment in the same cycle; the result is 0.

## Timing
- Latency is 3 cycles from input handshake (i_valid & o_ready) to o_valid for that word.
- Advance enable: adv = ~o_valid | i_ready. All three stages shift together when adv = 1. Bubbles are not collapsed.
- o_ready = adv, combinational from i_ready and o_valid.
- When adv = 0, all stage registers and valid bits hold, and o_diff* stays stable.
- Throughput is 1 word/cycle with i_ready held high.
- Reset (asynchronous, any cycle including mid-stream):
  - All stage valid bits are cleared, so o_valid = 0.
  - o_diffFR = 0, o_diff_round_sat = 0, o_sat_flag = 0, o_sat_cnt = 0.
  - In-flight words are discarded.
- Output data is don't-care while o_valid = 0. The bench must not check data in that state.

## Structure
- Package sub_fp_pkg holds:
  - the max() constant function;
  - the derived-width functions (NBI_FR, NBF_FR, NB_FR);
  - the saturation-constant helpers (max positive and max negative for a given width).
- Sub-module fp_round_sat is the combinational round-half-up-and-saturate stage, parameterized by input and output formats. It is instantiated in stage 3 and reusable by the adder.
- Top-level contains the pipeline registers, handshake logic and counter.

## Test plan
- Basic difference: A=0x4000 (1.0), B=0x400 (0.5), i_ready=1.
  - Expect o_diffFR=0x02000 and o_diff_round_sat=0x200, three cycles after the input handshake.
  - Expect o_sat_flag=0.
- Positive saturation: A=0x7FFF, B=0x800 (−1.0).
  - Expect o_diff_round_sat=0x3FF, o_sat_flag=1, and o_sat_cnt incremented by 1.
- Negative saturation: A=0x8000 (−2.0), B=0x7FF.
  - Expect o_diff_round_sat=0x400 and o_sat_flag=1.
- Rounding ties, B=0:
  - A=0x0008 gives 0x001.
  - A=0xFFF8 gives 0x000.
  - A=0x0007 gives 0x000.
- Backpressure: stream 6 random words while dropping i_ready low for 4 cycles mid-stream.
  - Expect o_ready to drop in the same cycle as i_ready.
  - Expect no lost or duplicated words, and output order equal to input order.
- Counter and reset:
  - Force 300 saturating words; expect o_sat_cnt to stick at 0xFF.
  - Assert i_clear_cnt in the same cycle as a saturating handshake; expect o_sat_cnt=0.
  - Assert i_rst_n low mid-stream; expect o_valid=0 immediately (asynchronous) and all outputs at zero.
